// File: rtl/odd_stream_checker.sv
// ============================================================================
// odd_stream_checker
// ----------------------------------------------------------------------------
// Downstream consumer of the odd-number counter stage. Each run is framed by a
// start pulse. The block accepts num_terms odd values over a valid/ready
// handshake and keeps a running sum and a term count. At the end of the run
// it checks that sum == term_cnt^2, which holds for 1 + 3 + 5 + ...
//
// Optional feature (macro ODD_STREAM_SEQ_CHECK_EN):
//   When defined, every accepted value is compared with the expected odd
//   value (1, 3, 5, ... wrapping at the count width). A mismatch ends the run
//   with err_code 1. When undefined, bad sequences are caught only by the
//   final square compare (err_code 2).
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      one-cycle pulse; begins a run from IDLE, DONE or ERR
//   num_terms  terms per run, sampled on an accepted start
//   in_valid   count_in carries a new counter value this cycle
//   count_in   odd value from the counter stage (COUNT_LEN+1 bits)
//   in_ready   high only while accumulating
//   sum        running sum of accepted terms
//   term_cnt   number of accepted terms
//   busy       accumulating or checking
//   done       run finished and the square check passed
//   error      run finished with an error
//   err_code   0 none, 1 sequence mismatch, 2 square mismatch, 3 sum overflow
// ============================================================================
module odd_stream_checker #(
    parameter int COUNT_LEN = 10,
    parameter int SUM_W     = 24,
    parameter int TERM_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [TERM_W-1:0]  num_terms,
    input  logic               in_valid,
    input  logic [COUNT_LEN:0] count_in,
    output logic               in_ready,
    output logic [SUM_W-1:0]   sum,
    output logic [TERM_W-1:0]  term_cnt,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code
);

    localparam int CW = COUNT_LEN + 1;
    // Adder is one bit wider than the wider operand so the carry out of
    // SUM_W is always visible.
    localparam int AW = ((SUM_W > CW) ? SUM_W : CW) + 1;
    localparam int PW = 2 * TERM_W;
    localparam int QW = (SUM_W > PW) ? SUM_W : PW;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        CHECK,
        DONE,
        ERR
    } state_t;

    state_t            state_q, state_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [TERM_W-1:0] term_q, term_d;
    logic [TERM_W-1:0] num_q, num_d;
    logic [1:0]        err_q, err_d;
`ifdef ODD_STREAM_SEQ_CHECK_EN
    logic [CW-1:0]     expected_q, expected_d;
`endif

    logic [AW-1:0]     add_a, add_b, add_full;
    logic              overflow;
    logic [TERM_W-1:0] term_inc;
    logic [PW-1:0]     square;
    logic [QW-1:0]     square_ext, sum_ext;
    logic              square_ok;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sum_q      <= '0;
            term_q     <= '0;
            num_q      <= '0;
            err_q      <= 2'd0;
`ifdef ODD_STREAM_SEQ_CHECK_EN
            expected_q <= CW'(1);
`endif
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            term_q     <= term_d;
            num_q      <= num_d;
            err_q      <= err_d;
`ifdef ODD_STREAM_SEQ_CHECK_EN
            expected_q <= expected_d;
`endif
        end
    end

    // Arithmetic shared by the accept and check paths.
    always_comb begin
        add_a               = '0;
        add_a[SUM_W-1:0]    = sum_q;
        add_b               = '0;
        add_b[CW-1:0]       = count_in;
        add_full            = add_a + add_b;
        overflow            = |add_full[AW-1:SUM_W];
        term_inc            = term_q + TERM_W'(1);
        square              = {{TERM_W{1'b0}}, term_q} * {{TERM_W{1'b0}}, term_q};
        square_ext          = '0;
        square_ext[PW-1:0]  = square;
        sum_ext             = '0;
        sum_ext[SUM_W-1:0]  = sum_q;
        square_ok           = (square_ext == sum_ext);
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        term_d     = term_q;
        num_d      = num_q;
        err_d      = err_q;
`ifdef ODD_STREAM_SEQ_CHECK_EN
        expected_d = expected_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    num_d      = num_terms;
                    sum_d      = '0;
                    term_d     = '0;
                    err_d      = 2'd0;
`ifdef ODD_STREAM_SEQ_CHECK_EN
                    expected_d = CW'(1);
`endif
                    state_d    = (num_terms == '0) ? CHECK : ACCUM;
                end
            end
            ACCUM: begin
                // in_ready is decoded from ACCUM, so in_valid alone means accept.
                // A rejected term leaves sum and term_cnt untouched.
                if (in_valid) begin
                    if (overflow) begin
                        err_d   = 2'd3;
                        state_d = ERR;
                    end
`ifdef ODD_STREAM_SEQ_CHECK_EN
                    else if (count_in != expected_q) begin
                        err_d   = 2'd1;
                        state_d = ERR;
                    end
`endif
                    else begin
                        sum_d      = add_full[SUM_W-1:0];
                        term_d     = term_inc;
`ifdef ODD_STREAM_SEQ_CHECK_EN
                        expected_d = expected_q + CW'(2);
`endif
                        if (term_inc == num_q) begin
                            state_d = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                if (square_ok) begin
                    state_d = DONE;
                end else begin
                    err_d   = 2'd2;
                    state_d = ERR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: flags decoded from state, values straight from registers.
    always_comb begin
        in_ready = (state_q == ACCUM);
        busy     = (state_q == ACCUM) || (state_q == CHECK);
        done     = (state_q == DONE);
        error    = (state_q == ERR);
        sum      = sum_q;
        term_cnt = term_q;
        err_code = err_q;
    end

endmodule

// File: tb/tb_odd_stream_checker.sv
// ============================================================================
// tb_odd_stream_checker
// ----------------------------------------------------------------------------
// Drives two checker instances with the same stimulus: one with the default
// 24-bit accumulator and one with a 6-bit accumulator so the overflow path
// can be reached. Expected end-of-run results are queued per instance when a
// run is started; a monitor per instance pops and compares whenever that
// instance reaches done or error. Handshake timing, reset and ignored-input
// behaviour are checked directly from the stimulus process.
// ============================================================================
module tb_odd_stream_checker;

    localparam int COUNT_LEN = 10;
    localparam int TERM_W    = 8;

    typedef struct packed {
        logic        done;
        logic        error;
        logic [1:0]  code;
        logic [23:0] sum;
        logic [7:0]  terms;
    } resp_t;

    logic               clk;
    logic               reset;
    logic               start;
    logic [TERM_W-1:0]  num_terms;
    logic               in_valid;
    logic [COUNT_LEN:0] count_in;

    logic               in_ready_a, busy_a, done_a, error_a;
    logic [23:0]        sum_a;
    logic [7:0]         term_cnt_a;
    logic [1:0]         err_code_a;

    logic               in_ready_b, busy_b, done_b, error_b;
    logic [5:0]         sum_b;
    logic [7:0]         term_cnt_b;
    logic [1:0]         err_code_b;

    int    n_checks = 0;
    int    n_fail   = 0;
    resp_t exp_a_q[$];
    resp_t exp_b_q[$];
    logic  end_a_prev = 1'b0;
    logic  end_b_prev = 1'b0;

    odd_stream_checker #(.COUNT_LEN(COUNT_LEN), .SUM_W(24), .TERM_W(TERM_W)) dut_a (
        .clk(clk), .reset(reset), .start(start), .num_terms(num_terms),
        .in_valid(in_valid), .count_in(count_in), .in_ready(in_ready_a),
        .sum(sum_a), .term_cnt(term_cnt_a), .busy(busy_a), .done(done_a),
        .error(error_a), .err_code(err_code_a)
    );

    odd_stream_checker #(.COUNT_LEN(COUNT_LEN), .SUM_W(6), .TERM_W(TERM_W)) dut_b (
        .clk(clk), .reset(reset), .start(start), .num_terms(num_terms),
        .in_valid(in_valid), .count_in(count_in), .in_ready(in_ready_b),
        .sum(sum_b), .term_cnt(term_cnt_b), .busy(busy_b), .done(done_b),
        .error(error_b), .err_code(err_code_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic resp_t mkResp(input logic d, input logic e, input logic [1:0] c,
                                     input logic [23:0] s, input logic [7:0] t);
        resp_t r;
        r.done  = d;
        r.error = e;
        r.code  = c;
        r.sum   = s;
        r.terms = t;
        return r;
    endfunction

    task automatic startRun(input logic [7:0] n, input resp_t ea, input resp_t eb);
        exp_a_q.push_back(ea);
        exp_b_q.push_back(eb);
        start     = 1'b1;
        num_terms = n;
        tick();
        start     = 1'b0;
    endtask

    // Waits (bounded) for in_ready, then presents one term for one cycle.
    task automatic applyStimulus(input logic [COUNT_LEN:0] value, input int gap);
        repeat (gap) tick();
        for (int i = 0; i < 40; i++) begin
            if (in_ready_a) break;
            tick();
        end
        checkOutput("in_ready_before_term", in_ready_a, 1);
        in_valid = 1'b1;
        count_in = value;
        tick();
        in_valid = 1'b0;
        count_in = '0;
    endtask

    // Called right after the last accepting edge: one CHECK cycle, then the end state.
    task automatic checkEndTiming(input logic expect_done);
        checkOutput("busy_in_check", busy_a, 1);
        checkOutput("in_ready_in_check", in_ready_a, 0);
        checkOutput("no_early_end", done_a | error_a, 0);
        tick();
        checkOutput("done_after_check", done_a, expect_done);
        checkOutput("error_after_check", error_a, !expect_done);
        checkOutput("busy_after_check", busy_a, 0);
    endtask

    task automatic compareResp(input string tag, input resp_t e, input logic d,
                               input logic er, input logic [1:0] c,
                               input logic [23:0] s, input logic [7:0] t);
        checkOutput({tag, "_done"}, d, e.done);
        checkOutput({tag, "_error"}, er, e.error);
        checkOutput({tag, "_err_code"}, c, e.code);
        checkOutput({tag, "_sum"}, s, e.sum);
        checkOutput({tag, "_term_cnt"}, t, e.terms);
    endtask

    // Scoreboard monitors: compare on each entry into done/error.
    always @(negedge clk) begin
        if (!reset && (done_a || error_a) && !end_a_prev) begin
            if (exp_a_q.size() == 0) begin
                checkOutput("unexpected_end_a", exp_a_q.size(), 1);
            end else begin
                compareResp("run_a", exp_a_q.pop_front(), done_a, error_a,
                            err_code_a, sum_a, term_cnt_a);
            end
        end
        end_a_prev = !reset && (done_a || error_a);
    end

    always @(negedge clk) begin
        if (!reset && (done_b || error_b) && !end_b_prev) begin
            if (exp_b_q.size() == 0) begin
                checkOutput("unexpected_end_b", exp_b_q.size(), 1);
            end else begin
                compareResp("run_b", exp_b_q.pop_front(), done_b, error_b,
                            err_code_b, {18'd0, sum_b}, term_cnt_b);
            end
        end
        end_b_prev = !reset && (done_b || error_b);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        num_terms = '0;
        in_valid  = 1'b0;
        count_in  = '0;
        tick();
        tick();
        $display("[TB] reset state");
        checkOutput("reset_sum", sum_a, 0);
        checkOutput("reset_term_cnt", term_cnt_a, 0);
        checkOutput("reset_flags", {in_ready_a, busy_a, done_a, error_a}, 0);
        checkOutput("reset_err_code", err_code_a, 0);
        checkOutput("reset_flags_b", {in_ready_b, busy_b, done_b, error_b}, 0);
        reset = 1'b0;
        tick();

        $display("[TB] run 1: 1,3,5,7 with gaps");
        startRun(8'd4, mkResp(1, 0, 0, 24'd16, 8'd4), mkResp(1, 0, 0, 24'd16, 8'd4));
        checkOutput("in_ready_accum", in_ready_a, 1);
        applyStimulus(11'd1, 0);
        applyStimulus(11'd3, 2);
        applyStimulus(11'd5, 1);
        applyStimulus(11'd7, 3);
        checkEndTiming(1'b1);
        in_valid = 1'b1;
        count_in = 11'd9;
        tick();
        tick();
        in_valid = 1'b0;
        checkOutput("done_ignores_valid_sum", sum_a, 16);
        checkOutput("done_ignores_valid_terms", term_cnt_a, 4);
        checkOutput("done_held", done_a, 1);

        $display("[TB] run 2: zero terms");
        startRun(8'd0, mkResp(1, 0, 0, 24'd0, 8'd0), mkResp(1, 0, 0, 24'd0, 8'd0));
        checkEndTiming(1'b1);
        checkOutput("zero_terms_sum", sum_a, 0);

        $display("[TB] run 3: bad sequence");
`ifdef ODD_STREAM_SEQ_CHECK_EN
        startRun(8'd4, mkResp(0, 1, 1, 24'd4, 8'd2), mkResp(0, 1, 1, 24'd4, 8'd2));
        applyStimulus(11'd1, 0);
        applyStimulus(11'd3, 1);
        applyStimulus(11'd6, 0);
        checkOutput("seq_error_immediate", error_a, 1);
        checkOutput("seq_err_code", err_code_a, 1);
`else
        startRun(8'd4, mkResp(0, 1, 2, 24'd17, 8'd4), mkResp(0, 1, 2, 24'd17, 8'd4));
        applyStimulus(11'd1, 0);
        applyStimulus(11'd3, 1);
        applyStimulus(11'd6, 0);
        applyStimulus(11'd7, 2);
        checkEndTiming(1'b0);
        checkOutput("square_err_code", err_code_a, 2);
`endif

        $display("[TB] run 4: eight terms, narrow accumulator overflows");
        startRun(8'd8, mkResp(1, 0, 0, 24'd64, 8'd8), mkResp(0, 1, 3, 24'd49, 8'd7));
        for (int k = 0; k < 8; k++) begin
            applyStimulus(11'(2 * k + 1), k % 2);
        end
        checkOutput("overflow_err_b", error_b, 1);
        checkOutput("overflow_code_b", err_code_b, 3);
        checkEndTiming(1'b1);

        $display("[TB] run 5: ignored start, then reset mid-run");
        startRun(8'd4, mkResp(1, 0, 0, 24'd1, 8'd1), mkResp(1, 0, 0, 24'd1, 8'd1));
        applyStimulus(11'd1, 0);
        applyStimulus(11'd3, 0);
        start     = 1'b1;
        num_terms = 8'd2;
        tick();
        start     = 1'b0;
        checkOutput("start_ignored_sum", sum_a, 4);
        checkOutput("start_ignored_terms", term_cnt_a, 2);
        checkOutput("start_ignored_ready", in_ready_a, 1);
        reset = 1'b1;
        tick();
        checkOutput("midrun_reset_sum", sum_a, 0);
        checkOutput("midrun_reset_terms", term_cnt_a, 0);
        checkOutput("midrun_reset_flags", {in_ready_a, busy_a, done_a, error_a}, 0);
        checkOutput("midrun_reset_err_code", err_code_a, 0);
        reset = 1'b0;
        tick();
        // The aborted run's expectation is replaced by a fresh one-term run.
        start     = 1'b1;
        num_terms = 8'd1;
        tick();
        start     = 1'b0;
        applyStimulus(11'd1, 0);
        checkEndTiming(1'b1);

        repeat (3) tick();
        checkOutput("queue_a_drained", exp_a_q.size(), 0);
        checkOutput("queue_b_drained", exp_b_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
